// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: data width, register index width and writeback result encodings.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } resultSrcE;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero
// and write-first bypass so a value committed this cycle is already visible to decode.
module regfile_2r1w #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  // Entry 0 is not stored at all; x0 is produced by the read-side masking.
  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file and serves decode reads.
// Define WB_RETIRE_CNT_EN to add the ValidW input and the 64-bit InstretW retire counter.
import riscv_pkg::*;

module wb_regfile #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   RdW,
  input  logic [AW-1:0]   Rs1D,
  input  logic [AW-1:0]   Rs2D,
`ifdef WB_RETIRE_CNT_EN
  input  logic            ValidW,
  output logic [63:0]     InstretW,
`endif
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW
);

  // Reserved and unknown select codes fall back to the ALU result so nothing goes X downstream.
  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      RES_MEM: ResultW = ReadDataW;
      RES_PC4: ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) uRegfile (
    .clk    (clk),
    .reset  (reset),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (Rs1D),
    .raddr2 (Rs2D),
    .rdata1 (RD1D),
    .rdata2 (RD2D)
  );

`ifdef WB_RETIRE_CNT_EN
  // Bubbles are excluded; stores and branches count even though they write no register.
  logic [63:0] instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (ValidW) begin
      instret <= instret + 64'd1;
    end
  end

  assign InstretW = instret;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor compares them.
module tb_wb_regfile;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW;
  logic [XLEN-1:0] ReadDataW;
  logic [XLEN-1:0] PCPlus4W;
  logic [AW-1:0]   RdW;
  logic [AW-1:0]   Rs1D;
  logic [AW-1:0]   Rs2D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ResultW;
`ifdef WB_RETIRE_CNT_EN
  logic            ValidW;
  logic [63:0]     InstretW;
`endif

  typedef struct {
    string       name;
    int          kind;
    logic [63:0] exp;
  } expItemT;

  expItemT sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RdW        (RdW),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
`ifdef WB_RETIRE_CNT_EN
    .ValidW     (ValidW),
    .InstretW   (InstretW),
`endif
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW)
  );

  // Monitor: everything queued during this cycle is compared at the inactive edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      expItemT it;
      logic [63:0] act;
      it = sb.pop_front();
      case (it.kind)
        0: act = {32'd0, RD1D};
        1: act = {32'd0, RD2D};
        2: act = {32'd0, ResultW};
`ifdef WB_RETIRE_CNT_EN
        3: act = InstretW;
`endif
        default: act = 64'hX;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] src,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc4, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    RegWriteW  = we;
    ResultSrcW = src;
    ALUResultW = alu;
    ReadDataW  = mem;
    PCPlus4W   = pc4;
    RdW        = rd;
    Rs1D       = rs1;
    Rs2D       = rs2;
  endtask

  task automatic checkOutput(input string name, input int kind, input logic [63:0] exp);
    expItemT it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic idleRead(input logic [4:0] rs1, input logic [4:0] rs2);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2);
  endtask

  initial begin
    reset      = 1'b1;
    RegWriteW  = 1'b0;
    ResultSrcW = 2'b00;
    ALUResultW = '0;
    ReadDataW  = '0;
    PCPlus4W   = '0;
    RdW        = '0;
    Rs1D       = '0;
    Rs2D       = '0;
`ifdef WB_RETIRE_CNT_EN
    ValidW     = 1'b0;
`endif

    idleRead(5'd1, 5'd31);
    checkOutput("reset_rd1_x1", 0, 64'd0);
    checkOutput("reset_rd2_x31", 1, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("reset_instret", 3, 64'd0);
`endif
    idleRead(5'd1, 5'd31);
    reset = 1'b0;

    // All registers read zero after reset
    for (int r = 1; r < 32; r++) begin
      idleRead(5'(r), 5'(32 - r));
      checkOutput("post_reset_rd1", 0, 64'd0);
      checkOutput("post_reset_rd2", 1, 64'd0);
    end

    // x0 write is discarded, even through the bypass
    applyStimulus(1'b1, 2'b00, 32'hDEAD, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_bypass_rd1", 0, 64'd0);
    checkOutput("x0_bypass_rd2", 1, 64'd0);
    checkOutput("x0_result", 2, 64'h0000DEAD);
    idleRead(5'd0, 5'd0);
    checkOutput("x0_after_rd1", 0, 64'd0);

    // Result select cycles through ALU, load data and PC+4
    applyStimulus(1'b1, 2'b00, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 5'd5);
    checkOutput("src_alu_byp1", 0, 64'h11);
    checkOutput("src_alu_byp2", 1, 64'h11);
    idleRead(5'd5, 5'd0);
    checkOutput("src_alu_arr", 0, 64'h11);
    applyStimulus(1'b1, 2'b01, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 5'd1);
    checkOutput("src_mem_byp", 0, 64'h22);
    checkOutput("src_mem_other", 1, 64'd0);
    idleRead(5'd0, 5'd5);
    checkOutput("src_mem_arr", 1, 64'h22);
    applyStimulus(1'b1, 2'b10, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 5'd5);
    checkOutput("src_pc4_byp", 0, 64'h33);
    idleRead(5'd5, 5'd5);
    checkOutput("src_pc4_arr1", 0, 64'h33);
    checkOutput("src_pc4_arr2", 1, 64'h33);
    applyStimulus(1'b0, 2'b11, 32'h11, 32'h22, 32'h33, 5'd5, 5'd5, 5'd0);
    checkOutput("src_rsv_result", 2, 64'h11);
    checkOutput("src_rsv_nowrite", 0, 64'h33);

    // Same-cycle write and dual read of the same register
    applyStimulus(1'b1, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    checkOutput("byp_same_rd1", 0, 64'hA5A5A5A5);
    checkOutput("byp_same_rd2", 1, 64'hA5A5A5A5);
    idleRead(5'd7, 5'd5);
    checkOutput("arr_x7", 0, 64'hA5A5A5A5);
    checkOutput("arr_x5_kept", 1, 64'h33);

    // Bubble with RegWriteW low must not write
    applyStimulus(1'b0, 2'b00, 32'hFFFF, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
    checkOutput("bubble_rd_same", 0, 64'd0);
    idleRead(5'd3, 5'd3);
    checkOutput("bubble_rd_next", 0, 64'd0);

    // Async reset clears the array with no clock edge
    applyStimulus(1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
    idleRead(5'd9, 5'd9);
    checkOutput("x9_written", 0, 64'h1234);
    idleRead(5'd9, 5'd7);
    #1;
    reset = 1'b1;
    checkOutput("async_rst_x9", 0, 64'd0);
    checkOutput("async_rst_x7", 1, 64'd0);

    // Write attempted while reset is held
    applyStimulus(1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd10, 5'd10, 5'd9);
    checkOutput("rst_write_byp", 0, 64'h55);
    checkOutput("rst_write_other", 1, 64'd0);
    idleRead(5'd10, 5'd5);
    checkOutput("rst_write_lost", 0, 64'd0);
    checkOutput("rst_x5_cleared", 1, 64'd0);
    reset = 1'b0;
    idleRead(5'd10, 5'd9);
    checkOutput("post_rst_x10", 0, 64'd0);

`ifdef WB_RETIRE_CNT_EN
    // Ten valid instructions spread over thirteen cycles with three bubbles
    for (int c = 0; c < 13; c++) begin
      idleRead(5'd0, 5'd0);
      ValidW = !(c == 2 || c == 6 || c == 9);
    end
    idleRead(5'd0, 5'd0);
    ValidW = 1'b0;
    checkOutput("instret_10", 3, 64'd10);
`endif

    @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
